// File: rtl/fc_rowpar_ctrl.sv
// Sequencer for a row-parallel fully connected layer: loads the input vector,
// walks R-row groups over the shared vector memory and weight banks, then drains the accumulators.
module fc_rowpar_ctrl #(
    parameter int M = 8,
    parameter int N = 6,
    parameter int R = 2,
    localparam int G  = M / R,
    localparam int AW = (G * N > 1) ? $clog2(G * N) : 1,
    localparam int XW = (N > 1) ? $clog2(N) : 1,
    localparam int SW = (R > 1) ? $clog2(R) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          input_valid,
    output logic          input_ready,
    input  logic          output_ready,
    output logic          output_valid,
    output logic [XW-1:0] addr_x,
    output logic          wr_en_x,
    output logic [AW-1:0] addr_w,
    output logic          clear_acc,
    output logic          en_acc,
    output logic [SW-1:0] sel_out
);

    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(N - 1);
    localparam logic [SW-1:0] R_LAST = SW'(R - 1);
    localparam logic [GW-1:0] G_LAST = GW'(G - 1);

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_MAC   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [XW-1:0] cnt_x_r, cnt_x_s;
    logic [XW-1:0] k_r, k_s;
    logic [GW-1:0] g_r, g_s;
    logic [SW-1:0] r_r, r_s;
    // Weight address runs linearly through g*N+k across groups, so it is kept as its own counter
    logic [AW-1:0] wcnt_r, wcnt_s;

    // State and counter registers; en_acc is the MAC issue strobe delayed to match read latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_LOAD;
            cnt_x_r <= {XW{1'b0}};
            k_r     <= {XW{1'b0}};
            g_r     <= {GW{1'b0}};
            r_r     <= {SW{1'b0}};
            wcnt_r  <= {AW{1'b0}};
            en_acc  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_x_r <= cnt_x_s;
            k_r     <= k_s;
            g_r     <= g_s;
            r_r     <= r_s;
            wcnt_r  <= wcnt_s;
            en_acc  <= (state_r == ST_MAC);
        end
    end

    // Next-state, counter updates and per-state strobes
    always_comb begin
        state_s      = state_r;
        cnt_x_s      = cnt_x_r;
        k_s          = k_r;
        g_s          = g_r;
        r_s          = r_r;
        wcnt_s       = wcnt_r;
        input_ready  = 1'b0;
        wr_en_x      = 1'b0;
        clear_acc    = 1'b0;
        output_valid = 1'b0;
        addr_x       = k_r;
        addr_w       = wcnt_r;
        sel_out      = r_r;
        case (state_r)
            ST_LOAD: begin
                input_ready = ~reset;
                wr_en_x     = input_valid & ~reset;
                addr_x      = cnt_x_r;
                if (input_valid) begin
                    if (cnt_x_r == X_LAST) begin
                        cnt_x_s = {XW{1'b0}};
                        state_s = ST_CLEAR;
                    end else begin
                        cnt_x_s = cnt_x_r + 1'b1;
                    end
                end else begin
                    cnt_x_s = cnt_x_r;
                end
            end
            ST_CLEAR: begin
                clear_acc = 1'b1;
                k_s       = {XW{1'b0}};
                state_s   = ST_MAC;
            end
            ST_MAC: begin
                wcnt_s = wcnt_r + 1'b1;
                if (k_r == X_LAST) begin
                    state_s = ST_WAIT;
                end else begin
                    k_s = k_r + 1'b1;
                end
            end
            ST_WAIT: begin
                state_s = ST_DRAIN;
            end
            ST_DRAIN: begin
                output_valid = 1'b1;
                if (output_ready) begin
                    if (r_r == R_LAST) begin
                        r_s = {SW{1'b0}};
                        if (g_r == G_LAST) begin
                            g_s     = {GW{1'b0}};
                            wcnt_s  = {AW{1'b0}};
                            state_s = ST_LOAD;
                        end else begin
                            g_s     = g_r + 1'b1;
                            state_s = ST_CLEAR;
                        end
                    end else begin
                        r_s = r_r + 1'b1;
                    end
                end else begin
                    r_s = r_r;
                end
            end
            default: begin
                state_s = ST_LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_fc_rowpar_ctrl.sv
// Bench for fc_rowpar_ctrl: two instances (M=8,N=6,R=2 and M=4,N=1,R=4) driving a behavioural
// vector memory / weight ROM / accumulator datapath, checked cycle by cycle against a phase model.
module tb_fc_rowpar_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       iv_a, ir_a, or_a, ov_a, we_a, ca_a, ea_a;
    logic [2:0] ax_a;
    logic [4:0] aw_a;
    logic [0:0] so_a;
    logic       iv_b, ir_b, or_b, ov_b, we_b, ca_b, ea_b;
    logic [0:0] ax_b;
    logic [0:0] aw_b;
    logic [1:0] so_b;

    fc_rowpar_ctrl #(.M(8), .N(6), .R(2)) dut_a (
        .clk(clk), .reset(rst), .input_valid(iv_a), .input_ready(ir_a),
        .output_ready(or_a), .output_valid(ov_a), .addr_x(ax_a), .wr_en_x(we_a),
        .addr_w(aw_a), .clear_acc(ca_a), .en_acc(ea_a), .sel_out(so_a)
    );

    fc_rowpar_ctrl #(.M(4), .N(1), .R(4)) dut_b (
        .clk(clk), .reset(rst), .input_valid(iv_b), .input_ready(ir_b),
        .output_ready(or_b), .output_valid(ov_b), .addr_x(ax_b), .wr_en_x(we_b),
        .addr_w(aw_b), .clear_acc(ca_b), .en_acc(ea_b), .sel_out(so_b)
    );

    int ntest = 0;
    int nfail = 0;
    int cyc   = 0;

    int pm [2] = '{8, 4};
    int pn [2] = '{6, 1};
    int pr [2] = '{2, 4};

    // Model state: ph 0=loading, 1=computing (off = cycles since group start), 2=draining
    int ph [2] = '{0, 0};
    int nacc [2] = '{0, 0};
    int grp [2] = '{0, 0};
    int off [2] = '{0, 0};
    int row [2] = '{0, 0};
    int xref [2][8];
    int xdat [2] = '{0, 0};

    int xmem [2][8];
    int xq [2];
    int wq [2][4];
    int acc [2][4];

    int n_clr [2] = '{0, 0};
    int n_en [2] = '{0, 0};
    int n_out [2] = '{0, 0};
    int n_wr [2] = '{0, 0};

    string fn [8] = '{"input_ready", "wr_en_x", "addr_x", "addr_w",
                      "clear_acc", "en_acc", "output_valid", "sel_out"};

    function automatic int wval(int r, int c);
        return r + c + 1;
    endfunction

    function automatic int rom(int d, int e, int b);
        return wval((e / pn[d]) * pr[d] + b, e % pn[d]);
    endfunction

    function automatic int yrow(int d, int r);
        int s = 0;
        for (int c = 0; c < pn[d]; c++) s += wval(r, c) * xref[d][c];
        return s;
    endfunction

    // Behavioural datapath: registered memory/ROM reads feeding the accumulators
    always @(posedge clk) begin
        if (we_a) xmem[0][ax_a] <= xdat[0];
        xq[0] <= xmem[0][ax_a];
        for (int b = 0; b < 2; b++) begin
            wq[0][b] <= rom(0, int'(aw_a), b);
            if (ca_a) acc[0][b] <= 0;
            else if (ea_a) acc[0][b] <= acc[0][b] + xq[0] * wq[0][b];
        end
        if (we_b) xmem[1][ax_b] <= xdat[1];
        xq[1] <= xmem[1][ax_b];
        for (int b = 0; b < 4; b++) begin
            wq[1][b] <= rom(1, int'(aw_b), b);
            if (ca_b) acc[1][b] <= 0;
            else if (ea_b) acc[1][b] <= acc[1][b] + xq[1] * wq[1][b];
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        ntest++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_dut(input int d, input int a [8], input int iv, input int rd);
        int e [8];
        bit ck [8];
        e  = '{default: 0};
        ck = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        if (rst) begin
            ck = '{default: 1'b1};
        end else if (ph[d] == 0) begin
            e[0] = 1; e[1] = iv; e[2] = nacc[d]; ck[2] = 1'b1;
        end else if (ph[d] == 1) begin
            e[4] = (off[d] == 0) ? 1 : 0;
            e[5] = (off[d] >= 2) ? 1 : 0;
            if (off[d] >= 1 && off[d] <= pn[d]) begin
                e[2] = off[d] - 1;
                e[3] = grp[d] * pn[d] + off[d] - 1;
                ck[2] = 1'b1; ck[3] = 1'b1;
            end
        end else begin
            e[6] = 1; e[7] = row[d] % pr[d]; ck[7] = 1'b1;
            if (rd != 0) chk($sformatf("d%0d y_row%0d", d, row[d]), acc[d][a[7] % 4], yrow(d, row[d]));
        end
        for (int i = 0; i < 8; i++)
            if (ck[i]) chk($sformatf("d%0d %s", d, fn[i]), a[i], e[i]);
    endtask

    task automatic step_model(input int d, input int iv, input int rd);
        if (rst) begin
            ph[d] = 0; nacc[d] = 0; grp[d] = 0; off[d] = 0; row[d] = 0;
        end else if (ph[d] == 0) begin
            if (iv != 0) begin
                xref[d][nacc[d]] = xdat[d];
                nacc[d]++;
                if (nacc[d] == pn[d]) begin
                    ph[d] = 1; off[d] = 0; grp[d] = 0; row[d] = 0;
                end
            end
        end else if (ph[d] == 1) begin
            if (off[d] == pn[d] + 1) ph[d] = 2;
            else off[d]++;
        end else if (rd != 0) begin
            row[d]++;
            if (row[d] % pr[d] == 0) begin
                if (row[d] == pm[d]) begin
                    ph[d] = 0; nacc[d] = 0;
                end else begin
                    grp[d]++; ph[d] = 1; off[d] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        int a [2][8];
        int iv [2];
        int rd [2];
        #1;
        a[0] = '{int'(ir_a), int'(we_a), int'(ax_a), int'(aw_a), int'(ca_a), int'(ea_a), int'(ov_a), int'(so_a)};
        a[1] = '{int'(ir_b), int'(we_b), int'(ax_b), int'(aw_b), int'(ca_b), int'(ea_b), int'(ov_b), int'(so_b)};
        iv = '{int'(iv_a), int'(iv_b)};
        rd = '{int'(or_a), int'(or_b)};
        for (int d = 0; d < 2; d++) begin
            check_dut(d, a[d], iv[d], rd[d]);
            n_clr[d] += a[d][4];
            n_en[d]  += a[d][5];
            n_wr[d]  += a[d][1];
            if (a[d][6] != 0 && rd[d] != 0) n_out[d]++;
            step_model(d, iv[d], rd[d]);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clr_counts();
        n_clr = '{0, 0}; n_en = '{0, 0}; n_out = '{0, 0}; n_wr = '{0, 0};
    endtask

    task automatic load_a(input int v [6]);
        for (int i = 0; i < 6; i++) begin
            iv_a = 1'b1; xdat[0] = v[i];
            tick();
        end
        iv_a = 1'b0;
    endtask

    task automatic run_load(input int d, input int budget);
        int bud = budget;
        while (ph[d] != 0 && bud > 0) begin
            tick();
            bud--;
        end
        chk($sformatf("d%0d return_to_load", d), ph[d], 0);
    endtask

    initial begin
        int t_acc, first_ov, bud, stall;
        iv_a = 1'b0; or_a = 1'b1; iv_b = 1'b0; or_b = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Nominal layer, back-to-back input, no back-pressure
        clr_counts();
        for (int i = 0; i < 6; i++) begin
            iv_a = 1'b1; xdat[0] = i + 1;
            t_acc = cyc;
            tick();
        end
        iv_a = 1'b0;
        chk("nominal writes", n_wr[0], 6);
        first_ov = -1;
        bud = 200;
        while (ph[0] != 0 && bud > 0) begin
            if (ov_a && first_ov < 0) begin
                first_ov = cyc;
                chk("first word row0", acc[0][0], 91);
            end
            tick();
            bud--;
        end
        chk("output_valid latency", first_ov - (t_acc + 1), 8);
        chk("return to LOAD", cyc - (t_acc + 1), 40);
        chk("input_ready back in LOAD", int'(ir_a), 1);
        chk("clear pulses", n_clr[0], 4);
        chk("en_acc cycles", n_en[0], 24);
        chk("rows out", n_out[0], 8);

        // Input bubbles, then input_valid held high while busy, with a 3-cycle output stall in group 1
        clr_counts();
        for (int i = 0; i < 12; i++) begin
            iv_a = (i % 2 == 0) ? 1'b1 : 1'b0;
            xdat[0] = 10 + i;
            tick();
        end
        chk("bubble writes", n_wr[0], 6);
        stall = 0;
        bud = 200;
        xdat[0] = 99;
        while (ph[0] != 0 && bud > 0) begin
            iv_a = 1'b1;
            if (ph[0] == 2 && grp[0] == 1 && row[0] == 3 && stall < 3) begin
                or_a = 1'b0;
                stall++;
            end else begin
                or_a = 1'b1;
            end
            tick();
            bud--;
        end
        iv_a = 1'b0; or_a = 1'b1;
        chk("stalled layer return", ph[0], 0);
        chk("stalled layer rows", n_out[0], 8);
        chk("busy writes", n_wr[0], 6);

        // Reset during MAC k=3, then a full fresh layer
        load_a('{3, 1, 4, 1, 5, 9});
        bud = 50;
        while (!(ph[0] == 1 && off[0] == 4) && bud > 0) begin
            tick();
            bud--;
        end
        chk("reached MAC k=3", off[0], 4);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clr_counts();
        load_a('{2, 7, 1, 8, 2, 8});
        run_load(0, 200);
        chk("post-reset rows", n_out[0], 8);

        // Degenerate instance: one group, one MAC issue, four outputs
        clr_counts();
        iv_b = 1'b1; xdat[1] = 7;
        tick();
        iv_b = 1'b0;
        run_load(1, 50);
        chk("degenerate clears", n_clr[1], 1);
        chk("degenerate en_acc cycles", n_en[1], 1);
        chk("degenerate rows", n_out[1], 4);
        chk("degenerate last word", acc[1][3], 28);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
